sc_frog_move_ctrl: RTL and testbench
====================================

Name: sc_frog_move_ctrl

Overview:
- Parametrised Moore controller for frog movement in the Frogger datapath.
- Decodes the game command and four active-low direction buttons into single-cycle control strobes for the frog position registers: init, clear, row load up/down, and column shift left/right.
- Adds features the first-generation controller lacks: edge blocking on all four sides, hold-to-repeat with configurable delay and rate, and a wrapping move counter for the score/status logic.

Parameters:
- REPEAT_DELAY, 24'd12_500_000, cycles a button must stay held before the first auto-repeat move (≥2).
- REPEAT_RATE, 24'd5_000_000, cycles between later auto-repeat moves (≥2).
- TMR_W, 24, width of the hold timer.
- CNT_W, 8, width of the move counter.

Ports:
- SC_STATEMACHINEFROGGER_CLOCK_50  in  1  system clock, 50 MHz
- SC_STATEMACHINEFROGGER_RESET_InHigh  in  1  asynchronous, active-high reset
- cmd_In  in  2  game command: 00 run, 01 freeze, 10 init, 11 clear
- upButton_InLow, downButton_InLow, leftButton_InLow, rightButton_InLow  in  1 each  debounced buttons, active low
- topEdge_InLow, bottomEdge_InLow, leftEdge_InLow, rightEdge_InLow  in  1 each  low = frog already at that edge
- clear_OutLow  out  1  clear strobe, active low
- init_OutLow  out  1  init strobe, active low
- load0_OutLow  out  1  row-up load strobe, active low
- load1_OutLow  out  1  row-down load strobe, active low
- shiftselection_Out  out  2  column shift: 11 hold, 01 left, 10 right
- moveCount_Out  out  CNT_W  number of accepted moves, wraps
- busy_Out  out  1  high in any state except IDLE

Behaviour:
- Reset (asynchronous, active high):
  - state = IDLE; timer = 0; first-repeat flag = 1; moveCount = 0.
  - Outputs go inactive: all *_OutLow = 1, shiftselection = 11, busy = 0.
- States: IDLE, INIT, CLEAR, UP, DOWN, LEFT, RIGHT, HOLD.
- Outputs are decoded from the state register only. A button sampled in cycle n produces its strobe in cycle n+1, lasting exactly one cycle.
- Command priority, checked from every state: 11 → CLEAR; 10 → INIT; 01 → IDLE with timer cleared.
- Movement applies only when cmd = 00.
- IDLE direction decode, in priority order:
  - up with topEdge = 1 → UP
  - down with bottomEdge = 1 → DOWN
  - left with leftEdge = 1 → LEFT
  - right with rightEdge = 1 → RIGHT
  - otherwise stay in IDLE.
- A press that is blocked by its edge does not produce a move, and lower-priority buttons are still evaluated.
- UP, DOWN, LEFT and RIGHT:
  - Assert the matching strobe: UP → load0 = 0; DOWN → load1 = 0; LEFT → shift = 01; RIGHT → shift = 10.
  - moveCount is incremented modulo 2^CNT_W.
  - The direction is latched, and the next state is HOLD.
- INIT and CLEAR:
  - Assert the matching strobe for one cycle and set moveCount = 0.
  - The next state is HOLD if any button is pressed, otherwise IDLE.
- HOLD:
  - The latched direction button released → IDLE, timer = 0, first-repeat flag = 1.
  - Still held → timer increments.
  - When timer = threshold−1 (threshold = REPEAT_DELAY if the first-repeat flag is set, else REPEAT_RATE): go to the latched direction state if its edge is not blocked, then clear the timer and the first-repeat flag.
  - If the edge is blocked at that point, stay in HOLD and reload the timer to 0.
- After INIT or CLEAR, the latched direction is none, so HOLD only waits for all buttons to be released.
- A second button pressed while in HOLD is ignored until the latched button is released.
- Timer arithmetic is unsigned TMR_W bits. The threshold comparison uses equality, so the timer never wraps.

Optional Feature:
- Macro: SC_FROG_MOVE_AUTOREPEAT_EN.
- Defined: HOLD auto-repeats as described above.
- Undefined: the timer logic is removed. HOLD only waits for release, so one press gives exactly one move. REPEAT_DELAY and REPEAT_RATE are ignored.

Decomposition:
- Shared package sc_frog_pkg holds:
  - state encodings (3 bits);
  - command codes CMD_RUN, CMD_FREEZE, CMD_INIT, CMD_CLEAR;
  - shift codes SHIFT_HOLD = 11, SHIFT_LEFT = 01, SHIFT_RIGHT = 10.
- One sub-module, sc_frog_repeat_timer: the loadable hold timer with the first/rate threshold select and a hit output. It is instantiated only when SC_FROG_MOVE_AUTOREPEAT_EN is defined.

Test Plan:
- Reset asserted in the middle of HOLD with moveCount = 5 → within the same cycle all outputs are inactive and moveCount = 0; after release the state is IDLE.
- cmd = 00, up pulse held 1 cycle, topEdge = 1 → load0 low exactly 1 cycle, one cycle after the sample; moveCount 0 → 1.
- downButton held, bottomEdge = 0 → no load1 strobe, state stays IDLE; rightButton pressed at the same time → shift = 10 for one cycle.
- AUTOREPEAT_EN, REPEAT_DELAY = 4, REPEAT_RATE = 2, left held 12 cycles → LEFT strobes at cycles 1, 6, 9, 12; moveCount = 4.
- cmd = 11 while right is held → clear low for 1 cycle, moveCount = 0, then HOLD with no further moves until release.
- CNT_W = 2, 5 accepted moves → moveCount reads 1 (wrap-around); cmd = 01 during HOLD → IDLE next cycle, no strobes.

Source files
------------

// File: rtl/sc_frog_pkg.sv
// Shared encodings for the frog movement controller: FSM states, game commands,
// column-shift codes, latched move direction and hold-timer operations.
package sc_frog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_UP    = 3'd3,
    ST_DOWN  = 3'd4,
    ST_LEFT  = 3'd5,
    ST_RIGHT = 3'd6,
    ST_HOLD  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    CMD_RUN    = 2'b00,
    CMD_FREEZE = 2'b01,
    CMD_INIT   = 2'b10,
    CMD_CLEAR  = 2'b11
  } cmd_e;

  localparam logic [1:0] SHIFT_HOLD  = 2'b11;
  localparam logic [1:0] SHIFT_LEFT  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT = 2'b10;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  typedef enum logic [2:0] {
    TMR_KEEP    = 3'd0,
    TMR_INC     = 3'd1,
    TMR_RESTART = 3'd2,
    TMR_REARM   = 3'd3,
    TMR_FIRE    = 3'd4
  } tmr_op_e;

  function automatic state_e dir_to_state(input dir_e d);
    case (d)
      DIR_UP:    return ST_UP;
      DIR_DOWN:  return ST_DOWN;
      DIR_LEFT:  return ST_LEFT;
      DIR_RIGHT: return ST_RIGHT;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/sc_frog_move_ctrl_if.sv
// Command/button/edge inputs and strobe outputs of the frog movement controller.
interface sc_frog_move_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic [1:0]       cmd_In;
  logic             upButton_InLow;
  logic             downButton_InLow;
  logic             leftButton_InLow;
  logic             rightButton_InLow;
  logic             topEdge_InLow;
  logic             bottomEdge_InLow;
  logic             leftEdge_InLow;
  logic             rightEdge_InLow;
  logic             clear_OutLow;
  logic             init_OutLow;
  logic             load0_OutLow;
  logic             load1_OutLow;
  logic [1:0]       shiftselection_Out;
  logic [CNT_W-1:0] moveCount_Out;
  logic             busy_Out;

  modport master (
    output cmd_In, upButton_InLow, downButton_InLow, leftButton_InLow, rightButton_InLow,
    output topEdge_InLow, bottomEdge_InLow, leftEdge_InLow, rightEdge_InLow,
    input  clear_OutLow, init_OutLow, load0_OutLow, load1_OutLow,
    input  shiftselection_Out, moveCount_Out, busy_Out
  );

  modport slave (
    input  cmd_In, upButton_InLow, downButton_InLow, leftButton_InLow, rightButton_InLow,
    input  topEdge_InLow, bottomEdge_InLow, leftEdge_InLow, rightEdge_InLow,
    output clear_OutLow, init_OutLow, load0_OutLow, load1_OutLow,
    output shiftselection_Out, moveCount_Out, busy_Out
  );
endinterface

// File: rtl/sc_frog_repeat_timer.sv
// Hold timer for auto-repeat: counts held cycles and flags when the first-move
// delay or the repeat rate has elapsed. Used only with SC_FROG_MOVE_AUTOREPEAT_EN.
module sc_frog_repeat_timer
  import sc_frog_pkg::*;
#(
  parameter int unsigned      TMR_W        = 24,
  parameter logic [TMR_W-1:0] REPEAT_DELAY = 24'd12_500_000,
  parameter logic [TMR_W-1:0] REPEAT_RATE  = 24'd5_000_000
) (
  input  logic    SC_STATEMACHINEFROGGER_CLOCK_50,
  input  logic    SC_STATEMACHINEFROGGER_RESET_InHigh,
  input  tmr_op_e op_In,
  output logic    hit_Out
);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] threshold;
  logic             first_q, first_d;

  always_comb begin
    threshold = first_q ? REPEAT_DELAY : REPEAT_RATE;
    hit_Out   = (timer_q == threshold - TMR_W'(1));
  end

  always_comb begin
    timer_d = timer_q;
    first_d = first_q;
    case (op_In)
      TMR_INC:     timer_d = timer_q + TMR_W'(1);
      TMR_RESTART: timer_d = '0;
      TMR_REARM: begin
        timer_d = '0;
        first_d = 1'b1;
      end
      TMR_FIRE: begin
        timer_d = '0;
        first_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge SC_STATEMACHINEFROGGER_CLOCK_50 or posedge SC_STATEMACHINEFROGGER_RESET_InHigh) begin
    if (SC_STATEMACHINEFROGGER_RESET_InHigh) begin
      timer_q <= '0;
      first_q <= 1'b1;
    end else begin
      timer_q <= timer_d;
      first_q <= first_d;
    end
  end

endmodule

// File: rtl/sc_frog_move_ctrl.sv
// Moore controller turning game commands and direction buttons into frog move strobes.
// Define SC_FROG_MOVE_AUTOREPEAT_EN to enable hold-to-repeat moves.
module sc_frog_move_ctrl
  import sc_frog_pkg::*;
#(
  parameter int unsigned      TMR_W        = 24,
  parameter logic [TMR_W-1:0] REPEAT_DELAY = 24'd12_500_000,
  parameter logic [TMR_W-1:0] REPEAT_RATE  = 24'd5_000_000,
  parameter int unsigned      CNT_W        = 8
) (
  input logic                SC_STATEMACHINEFROGGER_CLOCK_50,
  input logic                SC_STATEMACHINEFROGGER_RESET_InHigh,
  sc_frog_move_ctrl_if.slave frog_bus
);

  if (REPEAT_DELAY < TMR_W'(2) || REPEAT_RATE < TMR_W'(2)) begin : g_bad_repeat_params
    $error("REPEAT_DELAY and REPEAT_RATE must be at least 2");
  end

  state_e           state_q, state_d;
  dir_e             dir_q, dir_d, press_dir;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_btn, dir_held, dir_edge_ok;

`ifdef SC_FROG_MOVE_AUTOREPEAT_EN
  tmr_op_e tmr_op;
  logic    tmr_hit;

  sc_frog_repeat_timer #(
    .TMR_W        (TMR_W),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat_timer (
    .SC_STATEMACHINEFROGGER_CLOCK_50     (SC_STATEMACHINEFROGGER_CLOCK_50),
    .SC_STATEMACHINEFROGGER_RESET_InHigh (SC_STATEMACHINEFROGGER_RESET_InHigh),
    .op_In                               (tmr_op),
    .hit_Out                             (tmr_hit)
  );
`endif

  // Button decode; DIR_NONE (after init/clear) means "wait until every button is up".
  always_comb begin
    any_btn   = ~&{frog_bus.upButton_InLow, frog_bus.downButton_InLow,
                   frog_bus.leftButton_InLow, frog_bus.rightButton_InLow};
    press_dir = DIR_NONE;
    if (!frog_bus.upButton_InLow && frog_bus.topEdge_InLow)             press_dir = DIR_UP;
    else if (!frog_bus.downButton_InLow && frog_bus.bottomEdge_InLow)   press_dir = DIR_DOWN;
    else if (!frog_bus.leftButton_InLow && frog_bus.leftEdge_InLow)     press_dir = DIR_LEFT;
    else if (!frog_bus.rightButton_InLow && frog_bus.rightEdge_InLow)   press_dir = DIR_RIGHT;
    case (dir_q)
      DIR_UP:    begin dir_held = !frog_bus.upButton_InLow;    dir_edge_ok = frog_bus.topEdge_InLow;    end
      DIR_DOWN:  begin dir_held = !frog_bus.downButton_InLow;  dir_edge_ok = frog_bus.bottomEdge_InLow; end
      DIR_LEFT:  begin dir_held = !frog_bus.leftButton_InLow;  dir_edge_ok = frog_bus.leftEdge_InLow;   end
      DIR_RIGHT: begin dir_held = !frog_bus.rightButton_InLow; dir_edge_ok = frog_bus.rightEdge_InLow;  end
      default:   begin dir_held = any_btn;                     dir_edge_ok = 1'b0;                      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef SC_FROG_MOVE_AUTOREPEAT_EN
    tmr_op  = TMR_KEEP;
`endif
    case (cmd_e'(frog_bus.cmd_In))
      CMD_CLEAR: begin
        state_d = ST_CLEAR;
        dir_d   = DIR_NONE;
        cnt_d   = '0;
      end
      CMD_INIT: begin
        state_d = ST_INIT;
        dir_d   = DIR_NONE;
        cnt_d   = '0;
      end
      CMD_FREEZE: begin
        state_d = ST_IDLE;
        dir_d   = DIR_NONE;
      end
      default: begin
        case (state_q)
          ST_IDLE: begin
            if (press_dir != DIR_NONE) begin
              state_d = dir_to_state(press_dir);
              dir_d   = press_dir;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
          ST_UP, ST_DOWN, ST_LEFT, ST_RIGHT: state_d = ST_HOLD;
          ST_INIT, ST_CLEAR:                 state_d = any_btn ? ST_HOLD : ST_IDLE;
          ST_HOLD: begin
            if (!dir_held) begin
              state_d = ST_IDLE;
              dir_d   = DIR_NONE;
            end
`ifdef SC_FROG_MOVE_AUTOREPEAT_EN
            else if (dir_q != DIR_NONE) begin
              if (!tmr_hit) begin
                tmr_op = TMR_INC;
              end else if (dir_edge_ok) begin
                state_d = dir_to_state(dir_q);
                cnt_d   = cnt_q + CNT_W'(1);
                tmr_op  = TMR_FIRE;
              end else begin
                tmr_op = TMR_RESTART;
              end
            end
`endif
          end
          default: state_d = ST_IDLE;
        endcase
      end
    endcase
`ifdef SC_FROG_MOVE_AUTOREPEAT_EN
    // Every path into IDLE/INIT/CLEAR (release, freeze, commands) re-arms the first-move delay.
    if (state_d == ST_IDLE || state_d == ST_INIT || state_d == ST_CLEAR) tmr_op = TMR_REARM;
`endif
  end

  always_ff @(posedge SC_STATEMACHINEFROGGER_CLOCK_50 or posedge SC_STATEMACHINEFROGGER_RESET_InHigh) begin
    if (SC_STATEMACHINEFROGGER_RESET_InHigh) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    frog_bus.clear_OutLow       = (state_q != ST_CLEAR);
    frog_bus.init_OutLow        = (state_q != ST_INIT);
    frog_bus.load0_OutLow       = (state_q != ST_UP);
    frog_bus.load1_OutLow       = (state_q != ST_DOWN);
    frog_bus.shiftselection_Out = SHIFT_HOLD;
    if (state_q == ST_LEFT)  frog_bus.shiftselection_Out = SHIFT_LEFT;
    if (state_q == ST_RIGHT) frog_bus.shiftselection_Out = SHIFT_RIGHT;
    frog_bus.moveCount_Out      = cnt_q;
    frog_bus.busy_Out           = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_sc_frog_move_ctrl.sv
// Directed bench for sc_frog_move_ctrl; auto-repeat expectations follow SC_FROG_MOVE_AUTOREPEAT_EN.
module tb_sc_frog_move_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_cnt  = 8'd0;

  always #5 clk = ~clk;

  sc_frog_move_ctrl_if #(.CNT_W(8)) bus ();
  sc_frog_move_ctrl_if #(.CNT_W(2)) bus_w ();

  sc_frog_move_ctrl #(
    .TMR_W(24), .REPEAT_DELAY(24'd4), .REPEAT_RATE(24'd2), .CNT_W(8)
  ) dut (
    .SC_STATEMACHINEFROGGER_CLOCK_50     (clk),
    .SC_STATEMACHINEFROGGER_RESET_InHigh (rst),
    .frog_bus                            (bus)
  );

  sc_frog_move_ctrl #(.CNT_W(2)) dut_w (
    .SC_STATEMACHINEFROGGER_CLOCK_50     (clk),
    .SC_STATEMACHINEFROGGER_RESET_InHigh (rst),
    .frog_bus                            (bus_w)
  );

  // {clear, init, load0, load1, shift}: idle 111111, up 110111, down 111011,
  // left 111101, right 111110, init 101111, clear 011111
  logic [5:0] strb, strb_w;
  assign strb   = {bus.clear_OutLow, bus.init_OutLow, bus.load0_OutLow,
                   bus.load1_OutLow, bus.shiftselection_Out};
  assign strb_w = {bus_w.clear_OutLow, bus_w.init_OutLow, bus_w.load0_OutLow,
                   bus_w.load1_OutLow, bus_w.shiftselection_Out};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.cmd_In = 2'b00;
    bus.upButton_InLow = 1'b1; bus.downButton_InLow = 1'b1;
    bus.leftButton_InLow = 1'b1; bus.rightButton_InLow = 1'b1;
    bus.topEdge_InLow = 1'b1; bus.bottomEdge_InLow = 1'b1;
    bus.leftEdge_InLow = 1'b1; bus.rightEdge_InLow = 1'b1;
    bus_w.cmd_In = 2'b00;
    bus_w.upButton_InLow = 1'b1; bus_w.downButton_InLow = 1'b1;
    bus_w.leftButton_InLow = 1'b1; bus_w.rightButton_InLow = 1'b1;
    bus_w.topEdge_InLow = 1'b1; bus_w.bottomEdge_InLow = 1'b1;
    bus_w.leftEdge_InLow = 1'b1; bus_w.rightEdge_InLow = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    n_checks++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL reset_strobes: got %b expected 111111", strb); end
    n_checks++; if (bus.moveCount_Out !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.moveCount_Out); end
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_Out); end
    n_checks++; if (bus_w.moveCount_Out !== 2'd0) begin n_fail++; $display("FAIL reset_count_w: got %0d expected 0", bus_w.moveCount_Out); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %b expected 0", bus.busy_Out); end
    exp_cnt = 8'd0;
  endtask

  task automatic test_up_pulse;
    bus.upButton_InLow = 1'b0;
    tick();
    exp_cnt++;
    n_checks++; if (strb !== 6'b110111) begin n_fail++; $display("FAIL up_strobe: got %b expected 110111", strb); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL up_count: got %0d expected %0d", bus.moveCount_Out, exp_cnt); end
    bus.upButton_InLow = 1'b1;
    tick();
    n_checks++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL up_one_cycle: got %b expected 111111", strb); end
    n_checks++; if (bus.busy_Out !== 1'b1) begin n_fail++; $display("FAIL up_hold_busy: got %b expected 1", bus.busy_Out); end
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL up_back_idle: got %b expected 0", bus.busy_Out); end
  endtask

  task automatic test_edge_block;
    bus.downButton_InLow = 1'b0;
    bus.bottomEdge_InLow = 1'b0;
    tick();
    n_checks++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL down_blocked: got %b expected 111111", strb); end
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL down_blocked_idle: got %b expected 0", bus.busy_Out); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL down_blocked_count: got %0d expected %0d", bus.moveCount_Out, exp_cnt); end
    bus.rightButton_InLow = 1'b0;
    tick();
    exp_cnt++;
    n_checks++; if (strb !== 6'b111110) begin n_fail++; $display("FAIL right_past_blocked: got %b expected 111110", strb); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL right_count: got %0d expected %0d", bus.moveCount_Out, exp_cnt); end
    idle_inputs();
    tick();
    n_checks++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL right_one_cycle: got %b expected 111111", strb); end
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL right_back_idle: got %b expected 0", bus.busy_Out); end
  endtask

  task automatic test_autorepeat;
    logic [12:0] mask, exp_mask;
    logic [10:0] blk_mask;
    mask = '0;
    bus.leftButton_InLow = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      mask[i] = (strb === 6'b111101);
    end
    bus.leftButton_InLow = 1'b1;
`ifdef SC_FROG_MOVE_AUTOREPEAT_EN
    exp_mask = 13'h1242;
    exp_cnt  = exp_cnt + 8'd4;
`else
    exp_mask = 13'h0002;
    exp_cnt  = exp_cnt + 8'd1;
`endif
    n_checks++; if (mask !== exp_mask) begin n_fail++; $display("FAIL left_repeat_cycles: got %b expected %b", mask, exp_mask); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL left_repeat_count: got %0d expected %0d", bus.moveCount_Out, exp_cnt); end
    tick(); tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL left_release_idle: got %b expected 0", bus.busy_Out); end
    // up held, then frog reaches the top edge: no repeat may fire
    bus.upButton_InLow = 1'b0;
    tick();
    exp_cnt++;
    n_checks++; if (strb !== 6'b110111) begin n_fail++; $display("FAIL up_first_move: got %b expected 110111", strb); end
    bus.topEdge_InLow = 1'b0;
    blk_mask = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      blk_mask[i] = (strb !== 6'b111111);
    end
    n_checks++; if (blk_mask !== 11'd0) begin n_fail++; $display("FAIL up_repeat_blocked: got %b expected 0", blk_mask); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL up_blocked_count: got %0d expected %0d", bus.moveCount_Out, exp_cnt); end
    idle_inputs();
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL up_blocked_release: got %b expected 0", bus.busy_Out); end
  endtask

  task automatic test_clear_while_held;
    logic [10:0] mask;
    bus.rightButton_InLow = 1'b0;
    tick(); tick();
    bus.cmd_In = 2'b11;
    tick();
    exp_cnt = 8'd0;
    n_checks++; if (strb !== 6'b011111) begin n_fail++; $display("FAIL clear_strobe: got %b expected 011111", strb); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL clear_count: got %0d expected 0", bus.moveCount_Out); end
    bus.cmd_In = 2'b00;
    mask = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      mask[i] = (strb !== 6'b111111);
    end
    n_checks++; if (mask !== 11'd0) begin n_fail++; $display("FAIL clear_hold_no_moves: got %b expected 0", mask); end
    n_checks++; if (bus.busy_Out !== 1'b1) begin n_fail++; $display("FAIL clear_hold_busy: got %b expected 1", bus.busy_Out); end
    bus.rightButton_InLow = 1'b1;
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL clear_release_idle: got %b expected 0", bus.busy_Out); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL clear_final_count: got %0d expected 0", bus.moveCount_Out); end
  endtask

  task automatic test_freeze_init;
    bus.downButton_InLow = 1'b0;
    tick();
    exp_cnt++;
    n_checks++; if (strb !== 6'b111011) begin n_fail++; $display("FAIL down_strobe: got %b expected 111011", strb); end
    tick();
    bus.cmd_In = 2'b01;
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL freeze_idle: got %b expected 0", bus.busy_Out); end
    n_checks++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL freeze_no_strobe: got %b expected 111111", strb); end
    tick();
    n_checks++; if ({strb, bus.busy_Out} !== 7'b1111110) begin n_fail++; $display("FAIL freeze_held: got %b expected 1111110", {strb, bus.busy_Out}); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL freeze_count: got %0d expected %0d", bus.moveCount_Out, exp_cnt); end
    bus.downButton_InLow = 1'b1;
    bus.cmd_In = 2'b10;
    tick();
    exp_cnt = 8'd0;
    n_checks++; if (strb !== 6'b101111) begin n_fail++; $display("FAIL init_strobe: got %b expected 101111", strb); end
    n_checks++; if (bus.moveCount_Out !== exp_cnt) begin n_fail++; $display("FAIL init_count: got %0d expected 0", bus.moveCount_Out); end
    bus.cmd_In = 2'b00;
    tick();
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL init_to_idle: got %b expected 0", bus.busy_Out); end
  endtask

  task automatic test_wrap;
    for (int k = 1; k <= 5; k++) begin
      bus_w.rightButton_InLow = 1'b0;
      tick();
      bus_w.rightButton_InLow = 1'b1;
      tick(); tick();
      if (k == 4) begin
        n_checks++; if (bus_w.moveCount_Out !== 2'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d expected 0", bus_w.moveCount_Out); end
      end
    end
    n_checks++; if (bus_w.moveCount_Out !== 2'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", bus_w.moveCount_Out); end
    n_checks++; if ({strb_w, bus_w.busy_Out} !== 7'b1111110) begin n_fail++; $display("FAIL wrap_idle: got %b expected 1111110", {strb_w, bus_w.busy_Out}); end
  endtask

  task automatic test_reset_mid_hold;
    for (int k = 0; k < 4; k++) begin
      bus.upButton_InLow = 1'b0;
      tick();
      bus.upButton_InLow = 1'b1;
      tick(); tick();
    end
    bus.upButton_InLow = 1'b0;
    tick(); tick();
    n_checks++; if (bus.moveCount_Out !== 8'd5) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 5", bus.moveCount_Out); end
    n_checks++; if (bus.busy_Out !== 1'b1) begin n_fail++; $display("FAIL pre_reset_hold: got %b expected 1", bus.busy_Out); end
    rst = 1'b1;
    #2;
    n_checks++; if (strb !== 6'b111111) begin n_fail++; $display("FAIL async_reset_strobes: got %b expected 111111", strb); end
    n_checks++; if (bus.moveCount_Out !== 8'd0) begin n_fail++; $display("FAIL async_reset_count: got %0d expected 0", bus.moveCount_Out); end
    n_checks++; if (bus.busy_Out !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy_Out); end
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    n_checks++; if ({strb, bus.busy_Out} !== 7'b1111110) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 1111110", {strb, bus.busy_Out}); end
  endtask

  initial begin
    test_reset();
    test_up_pulse();
    test_edge_block();
    test_autorepeat();
    test_clear_while_held();
    test_freeze_init();
    test_wrap();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
